// File: rtl/rename_ckpt_unit_pkg.sv
// rename_ckpt_unit_pkg: shared widths, mask/index types and checkpoint entry layout
package rename_ckpt_unit_pkg;
  localparam int N = 3;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int NUM_CKPT = 4;
  localparam int ARCH_W = $clog2(ARCH_REGS);
  localparam int PREG_W = $clog2(PHYS_REGS);
  localparam int CID_W = $clog2(NUM_CKPT);
  localparam int CNT_W = $clog2(N + 1);
  typedef logic [NUM_CKPT-1:0] b_mask_t;
  typedef logic [CID_W-1:0] ckpt_idx_t;
  typedef logic [PREG_W-1:0] preg_t;
  typedef preg_t [ARCH_REGS-1:0] map_t;
  typedef struct packed {
    map_t map;
    b_mask_t parent_mask;
  } ckpt_entry_t;
endpackage

// File: rtl/rename_ckpt_unit_ckpt_alloc.sv
// ckpt_alloc: picks up to N free checkpoint indices, lowest first, as one-hot grants
module ckpt_alloc
  import rename_ckpt_unit_pkg::*;
(
  input  b_mask_t                          free_mask,
  output logic    [N-1:0][NUM_CKPT-1:0]    grant
);
  b_mask_t avail;
  always_comb begin
    avail = free_mask;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = avail & (~avail + b_mask_t'(1));
      avail = avail & ~grant[i];
    end
  end
endmodule

// File: rtl/rename_ckpt_unit.sv
// rename_ckpt_unit: N-wide rename with speculative map table and internal branch checkpoints
module rename_ckpt_unit
  import rename_ckpt_unit_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        in_count,
  input  logic [N*ARCH_W-1:0]     in_rs1,
  input  logic [N*ARCH_W-1:0]     in_rs2,
  input  logic [N*ARCH_W-1:0]     in_rd,
  input  logic [N-1:0]            in_has_dest,
  input  logic [N-1:0]            in_is_branch,
  input  logic [CNT_W-1:0]        space_avail,
  input  logic [N*PREG_W-1:0]     free_regs,
  input  logic [CNT_W-1:0]        free_count,
  input  logic                    resolve_valid,
  input  ckpt_idx_t               resolve_id,
  input  logic                    resolve_mispred,
  output logic [CNT_W-1:0]        num_renamed,
  output logic [CNT_W-1:0]        regs_used,
  output logic [N*PREG_W-1:0]     out_p1,
  output logic [N*PREG_W-1:0]     out_p2,
  output logic [N*PREG_W-1:0]     out_tnew,
  output logic [N*PREG_W-1:0]     out_told,
  output logic [N*NUM_CKPT-1:0]   out_bmask,
  output logic [N*CID_W-1:0]      out_ckpt_id,
  output b_mask_t                 ckpt_active
);
  map_t map_q, map_w, map_d;
  b_mask_t act_q, act_d, mask_w, g;
  ckpt_entry_t ckpt_q [NUM_CKPT];
  ckpt_entry_t ckpt_d [NUM_CKPT];
  logic [N-1:0][NUM_CKPT-1:0] grant;
  logic rv, mis, cor, stop, ok, dst;
  preg_t told, tnew;
  int acc, dcnt, bcnt, nfree;
  ckpt_alloc u_alloc (.free_mask(~act_q), .grant(grant));
  assign rv = resolve_valid && act_q[resolve_id];
  assign mis = rv && resolve_mispred;
  assign cor = rv && !resolve_mispred;
  assign ckpt_active = reset ? '0 : act_q;
  always_comb begin
    map_w = map_q;
    mask_w = act_q;
    ckpt_d = ckpt_q;
    stop = mis;
    acc = 0;
    dcnt = 0;
    bcnt = 0;
    nfree = $countones(~act_q);
    ok = 1'b0;
    dst = 1'b0;
    g = '0;
    told = '0;
    tnew = '0;
    out_p1 = '0;
    out_p2 = '0;
    out_tnew = '0;
    out_told = '0;
    out_bmask = '0;
    out_ckpt_id = '0;
    for (int i = 0; i < N; i++) begin
      dst = in_has_dest[i] && in_rd[i*ARCH_W +: ARCH_W] != '0;
      ok = !stop && i < int'(in_count) && i < int'(space_avail) &&
           (!dst || dcnt < int'(free_count)) && (!in_is_branch[i] || bcnt < nfree);
      stop = stop || !ok;
      out_p1[i*PREG_W +: PREG_W] = map_w[in_rs1[i*ARCH_W +: ARCH_W]];
      out_p2[i*PREG_W +: PREG_W] = map_w[in_rs2[i*ARCH_W +: ARCH_W]];
      told = map_w[in_rd[i*ARCH_W +: ARCH_W]];
      tnew = told;
      if (ok && dst) begin
        tnew = free_regs[dcnt*PREG_W +: PREG_W];
        map_w[in_rd[i*ARCH_W +: ARCH_W]] = tnew;
        dcnt++;
      end
      out_told[i*PREG_W +: PREG_W] = told;
      out_tnew[i*PREG_W +: PREG_W] = tnew;
      out_bmask[i*NUM_CKPT +: NUM_CKPT] = mask_w;
      // snapshot already includes this branch's own dest (JAL link)
      if (ok && in_is_branch[i]) begin
        g = grant[bcnt];
        for (int j = 0; j < NUM_CKPT; j++)
          if (g[j]) begin
            out_ckpt_id[i*CID_W +: CID_W] = CID_W'(j);
            ckpt_d[j] = '{map: map_w, parent_mask: mask_w};
          end
        mask_w = mask_w | g;
        bcnt++;
      end
      if (ok) acc++;
    end
    if (cor)
      for (int j = 0; j < NUM_CKPT; j++) ckpt_d[j].parent_mask[resolve_id] = 1'b0;
    act_d = cor ? mask_w & ~(b_mask_t'(1) << resolve_id) : mask_w;
    map_d = mis ? ckpt_q[resolve_id].map : map_w;
    if (mis) act_d = ckpt_q[resolve_id].parent_mask;
    if (reset) begin
      acc = 0;
      dcnt = 0;
      out_p1 = '0;
      out_p2 = '0;
      out_tnew = '0;
      out_told = '0;
      out_bmask = '0;
      out_ckpt_id = '0;
    end
    num_renamed = CNT_W'(acc);
    regs_used = CNT_W'(dcnt);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < ARCH_REGS; a++) map_q[a] <= PREG_W'(a);
      act_q <= '0;
    end else begin
      map_q <= map_d;
      act_q <= act_d;
      ckpt_q <= ckpt_d;
    end
  end
endmodule

// File: tb/tb_rename_ckpt_unit.sv
// tb_rename_ckpt_unit: directed checks of rename, bypass, checkpoint alloc/restore and reset
module tb_rename_ckpt_unit;
  import rename_ckpt_unit_pkg::*;
  logic clock = 1'b0;
  logic reset;
  logic [CNT_W-1:0] in_count, space_avail, free_count, num_renamed, regs_used;
  logic [N*ARCH_W-1:0] in_rs1, in_rs2, in_rd;
  logic [N-1:0] in_has_dest, in_is_branch;
  logic [N*PREG_W-1:0] free_regs, out_p1, out_p2, out_tnew, out_told;
  logic resolve_valid, resolve_mispred;
  ckpt_idx_t resolve_id;
  logic [N*NUM_CKPT-1:0] out_bmask;
  logic [N*CID_W-1:0] out_ckpt_id;
  b_mask_t ckpt_active;
  int checks = 0;
  int errors = 0;

  rename_ckpt_unit dut (
    .clock(clock), .reset(reset), .in_count(in_count), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_has_dest(in_has_dest), .in_is_branch(in_is_branch),
    .space_avail(space_avail), .free_regs(free_regs), .free_count(free_count),
    .resolve_valid(resolve_valid), .resolve_id(resolve_id), .resolve_mispred(resolve_mispred),
    .num_renamed(num_renamed), .regs_used(regs_used), .out_p1(out_p1), .out_p2(out_p2),
    .out_tnew(out_tnew), .out_told(out_told), .out_bmask(out_bmask),
    .out_ckpt_id(out_ckpt_id), .ckpt_active(ckpt_active)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] fp(input logic [N*PREG_W-1:0] v, input int i);
    return 32'(v[i*PREG_W +: PREG_W]);
  endfunction

  function automatic logic [31:0] fb(input logic [N*NUM_CKPT-1:0] v, input int i);
    return 32'(v[i*NUM_CKPT +: NUM_CKPT]);
  endfunction

  function automatic logic [31:0] fc(input logic [N*CID_W-1:0] v, input int i);
    return 32'(v[i*CID_W +: CID_W]);
  endfunction

  task automatic idle();
    in_count = '0; space_avail = '0; free_count = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_has_dest = '0; in_is_branch = '0;
    free_regs = '0; resolve_valid = 1'b0; resolve_id = '0; resolve_mispred = 1'b0;
  endtask

  task automatic slot(input int i, input int rs1, input int rs2, input int rd,
                      input logic dest, input logic br);
    in_rs1[i*ARCH_W +: ARCH_W] = ARCH_W'(rs1);
    in_rs2[i*ARCH_W +: ARCH_W] = ARCH_W'(rs2);
    in_rd[i*ARCH_W +: ARCH_W] = ARCH_W'(rd);
    in_has_dest[i] = dest;
    in_is_branch[i] = br;
  endtask

  task automatic frees(input int a, input int b, input int c, input int n);
    free_regs = {PREG_W'(c), PREG_W'(b), PREG_W'(a)};
    free_count = CNT_W'(n);
  endtask

  task automatic nxt();
    @(posedge clock);
    #2;
    idle();
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    in_count = 3; space_avail = 3; frees(40, 41, 42, 3);
    slot(0, 0, 0, 5, 1, 0); slot(1, 0, 0, 6, 1, 0); slot(2, 0, 0, 7, 1, 0);
    @(posedge clock); @(posedge clock); #2; settle();
    chk("rst_num_renamed", num_renamed, 0);
    chk("rst_regs_used", regs_used, 0);
    chk("rst_tnew", out_tnew, 0);
    chk("rst_told", out_told, 0);
    chk("rst_ckpt_active", ckpt_active, 0);
    reset = 1'b0;
    #1;
    chk("t1_tnew0", fp(out_tnew, 0), 40);
    chk("t1_tnew1", fp(out_tnew, 1), 41);
    chk("t1_tnew2", fp(out_tnew, 2), 42);
    chk("t1_told2", fp(out_told, 2), 7);
    chk("t1_num_renamed", num_renamed, 3);
    chk("t1_regs_used", regs_used, 3);
    nxt();
    in_count = 3; space_avail = 3;
    slot(0, 5, 6, 0, 0, 0); slot(1, 7, 0, 0, 0, 0);
    settle();
    chk("t1_map5", fp(out_p1, 0), 40);
    chk("t1_map6", fp(out_p2, 0), 41);
    chk("t1_map7", fp(out_p1, 1), 42);
    chk("t1_map0", fp(out_p2, 1), 0);
    chk("t1_probe_used", regs_used, 0);
    nxt();
    in_count = 3; space_avail = 3; frees(43, 44, 45, 1);
    slot(0, 0, 0, 5, 1, 0); slot(1, 5, 0, 0, 1, 0); slot(2, 0, 0, 9, 1, 0);
    settle();
    chk("t2_num_renamed", num_renamed, 2);
    chk("t2_regs_used", regs_used, 1);
    chk("t2_bypass_p1", fp(out_p1, 1), 43);
    chk("t2_told0", fp(out_told, 0), 40);
    chk("t2_tnew0", fp(out_tnew, 0), 43);
    chk("t2_x0_tnew", fp(out_tnew, 1), 0);
    nxt();
    in_count = 3; space_avail = 3;
    slot(0, 0, 0, 0, 0, 1); slot(1, 0, 0, 0, 0, 1); slot(2, 0, 0, 0, 0, 1);
    settle();
    chk("t3a_num_renamed", num_renamed, 3);
    chk("t3a_id1", fc(out_ckpt_id, 1), 1);
    chk("t3a_id2", fc(out_ckpt_id, 2), 2);
    chk("t3a_bmask2", fb(out_bmask, 2), 3);
    nxt();
    in_count = 3; space_avail = 3;
    slot(0, 0, 0, 0, 0, 1); slot(1, 0, 0, 0, 0, 1); slot(2, 0, 0, 0, 0, 1);
    settle();
    chk("t3_active", ckpt_active, 7);
    chk("t3_num_renamed", num_renamed, 1);
    chk("t3_id0", fc(out_ckpt_id, 0), 3);
    chk("t3_bmask0", fb(out_bmask, 0), 7);
    nxt();
    settle();
    chk("t6_active_full", ckpt_active, 15);
    reset = 1'b1;
    in_count = 3; space_avail = 3; frees(20, 21, 22, 3);
    slot(0, 5, 0, 5, 1, 1);
    #1;
    chk("t6_rst_num_renamed", num_renamed, 0);
    chk("t6_rst_active", ckpt_active, 0);
    chk("t6_rst_p1", out_p1, 0);
    nxt();
    reset = 1'b0;
    in_count = 3; space_avail = 3;
    slot(0, 5, 7, 0, 0, 0); slot(1, 9, 0, 0, 0, 0);
    settle();
    chk("t6_active", ckpt_active, 0);
    chk("t6_map5", fp(out_p1, 0), 5);
    chk("t6_map7", fp(out_p2, 0), 7);
    chk("t6_map9", fp(out_p1, 1), 9);
    nxt();
    in_count = 3; space_avail = 3; frees(50, 51, 52, 3);
    slot(0, 0, 0, 1, 1, 1); slot(1, 0, 0, 0, 0, 1); slot(2, 1, 0, 3, 1, 0);
    settle();
    chk("t4_num_renamed", num_renamed, 3);
    chk("t4_regs_used", regs_used, 2);
    chk("t4_tnew2", fp(out_tnew, 2), 51);
    chk("t4_id0", fc(out_ckpt_id, 0), 0);
    chk("t4_id1", fc(out_ckpt_id, 1), 1);
    chk("t4_bmask1", fb(out_bmask, 1), 1);
    chk("t4_bmask2", fb(out_bmask, 2), 3);
    chk("t4_bypass_jal", fp(out_p1, 2), 50);
    nxt();
    resolve_valid = 1'b1; resolve_id = 0; resolve_mispred = 1'b1;
    in_count = 3; space_avail = 3; frees(53, 54, 55, 3);
    slot(0, 0, 0, 4, 1, 0);
    settle();
    chk("t4_pre_active", ckpt_active, 3);
    chk("t4_mis_num_renamed", num_renamed, 0);
    chk("t4_mis_regs_used", regs_used, 0);
    nxt();
    in_count = 3; space_avail = 3;
    slot(0, 1, 3, 0, 0, 0); slot(1, 4, 0, 0, 0, 0);
    settle();
    chk("t4_active", ckpt_active, 0);
    chk("t4_map1", fp(out_p1, 0), 50);
    chk("t4_map3", fp(out_p2, 0), 3);
    chk("t4_map4", fp(out_p1, 1), 4);
    nxt();
    in_count = 3; space_avail = 3;
    slot(0, 0, 0, 0, 0, 1); slot(1, 0, 0, 0, 0, 1); slot(2, 0, 0, 0, 0, 1);
    settle();
    chk("t5a_num_renamed", num_renamed, 3);
    nxt();
    in_count = 1; space_avail = 3;
    slot(0, 0, 0, 0, 0, 1);
    settle();
    chk("t5b_id0", fc(out_ckpt_id, 0), 3);
    nxt();
    resolve_valid = 1'b1; resolve_id = 1; resolve_mispred = 1'b0;
    in_count = 1; space_avail = 3;
    slot(0, 0, 0, 0, 0, 1);
    settle();
    chk("t5_active_full", ckpt_active, 15);
    chk("t5_same_cycle_blocked", num_renamed, 0);
    nxt();
    in_count = 1; space_avail = 3;
    slot(0, 0, 0, 0, 0, 1);
    settle();
    chk("t5_active_freed", ckpt_active, 13);
    chk("t5_num_renamed", num_renamed, 1);
    chk("t5_id0", fc(out_ckpt_id, 0), 1);
    chk("t5_bmask0", fb(out_bmask, 0), 13);
    nxt();
    in_count = 3; space_avail = 2; frees(10, 11, 12, 3);
    slot(0, 0, 0, 2, 1, 0); slot(1, 0, 0, 3, 1, 0); slot(2, 0, 0, 4, 1, 0);
    settle();
    chk("t7_active_realloc", ckpt_active, 15);
    chk("t7_space_limit", num_renamed, 2);
    chk("t7_regs_used", regs_used, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
